// File: rtl/sng_pkg.sv
// Shared types and parameter checks for the
// deterministic stochastic-number generator.
package sng_pkg;

  typedef enum logic {
    SNG_IDLE,
    SNG_RUN
  } sng_state_t;

  typedef enum logic {
    SNG_SHARED,
    SNG_CLKDIV
  } sng_mode_t;

  function automatic bit sng_stride_ok(
    input int width,
    input int stride
  );
    return (stride == 1 || stride == 2 || stride == 4) &&
           (width >= 3 || stride <= (1 << width));
  endfunction

endpackage

// File: rtl/sng_ref_counter.sv
// One WIDTH-bit reference counter stepping by STEP,
// chained through carry_in/carry_out for clock division.
module sng_ref_counter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv,
  input  logic             carry_in,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             carry_out,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] INC  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] TERM =
    {WIDTH{1'b1}} - WIDTH'(STEP - 1);

  logic [WIDTH-1:0] cnt;

  assign carry_out = carry_in && (cnt == TERM);
  // flag looks ahead so the owner can register it
  assign terminal  = (cnt_nxt == TERM);

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (adv && carry_in)
      cnt_nxt = cnt + INC;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/sng_dsc_stream.sv
// Multi-channel unary bitstream generator, shared or clock-division.
// Define SNG_DSC_STREAM_ACC_EN to add per-channel ones accumulators.
module sng_dsc_stream
  import sng_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*WIDTH-1:0]  bin_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*STRIDE-1:0] sn_out,
  output logic                     out_last
`ifdef SNG_DSC_STREAM_ACC_EN
  ,
  output logic [NUM_CH*(WIDTH*NUM_CH+1)-1:0] acc_out,
  output logic                               acc_valid
`endif
);

  if (!sng_stride_ok(WIDTH, STRIDE)) begin : g_bad_stride
    $error("sng_dsc_stream: illegal STRIDE");
  end
  if (NUM_CH < 1 || NUM_CH > 8 ||
      WIDTH * NUM_CH > 32) begin : g_bad_ch
    $error("sng_dsc_stream: illegal NUM_CH/WIDTH");
  end

  sng_state_t state, state_nxt;
  sng_mode_t  mode_r, mode_nxt;

  logic [NUM_CH*WIDTH-1:0]  opnd, opnd_nxt;
  logic [NUM_CH*STRIDE-1:0] sn_nxt;
  logic                     last_nxt;
  logic load, fire, adv, done;

  logic [NUM_CH-1:0][WIDTH-1:0] cnt_nxt;
  logic [NUM_CH-1:0] cin, cout, term;
  logic unused_carry;

  assign in_ready  = (state == SNG_IDLE);
  assign out_valid = (state == SNG_RUN);

  assign load = in_valid && in_ready;
  assign fire = out_valid && out_ready;
  assign adv  = fire && !out_last;
  assign done = fire && out_last;

  assign mode_nxt = load ? sng_mode_t'(mode) : mode_r;
  assign opnd_nxt = load ? bin_in : opnd;

  always_comb begin
    state_nxt = state;
    unique case (state)
      SNG_IDLE: if (load) state_nxt = SNG_RUN;
      SNG_RUN:  if (done) state_nxt = SNG_IDLE;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (c == 0) begin : g_lead
      assign cin[c] = 1'b1;
    end else begin : g_follow
      // ripple carry forms the mixed-radix frame counter
      assign cin[c] = (mode_r == SNG_CLKDIV) && cout[c-1];
    end

    sng_ref_counter #(
      .WIDTH (WIDTH),
      .STEP  (c == 0 ? STRIDE : 1)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .clear     (load),
      .adv       (adv),
      .carry_in  (cin[c]),
      .cnt_nxt   (cnt_nxt[c]),
      .carry_out (cout[c]),
      .terminal  (term[c])
    );
  end

  assign unused_carry = cout[NUM_CH-1];

  always_comb begin
    logic [WIDTH-1:0] ref_v;
    sn_nxt = '0;
    ref_v  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ref_v = (mode_nxt == SNG_SHARED) ?
              cnt_nxt[0] : cnt_nxt[c];
      for (int j = 0; j < STRIDE; j++)
        sn_nxt[c*STRIDE+j] =
          opnd_nxt[c*WIDTH +: WIDTH] > ref_v + WIDTH'(j);
    end
  end

  assign last_nxt = (mode_nxt == SNG_SHARED) ?
                    term[0] : &term;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SNG_IDLE;
      mode_r   <= SNG_SHARED;
      opnd     <= '0;
      sn_out   <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mode_r <= mode_nxt;
        opnd   <= opnd_nxt;
      end
      if (load || adv) begin
        sn_out   <= sn_nxt;
        out_last <= last_nxt;
      end else if (done) begin
        out_last <= 1'b0;
      end
    end
  end

`ifdef SNG_DSC_STREAM_ACC_EN
  localparam int AW = WIDTH * NUM_CH + 1;

  logic [NUM_CH-1:0][AW-1:0] acc, pop;

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < STRIDE; j++)
        pop[c] = pop[c] + AW'(sn_out[c*STRIDE+j]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= done;
      if (load)
        acc <= '0;
      else if (fire)
        for (int c = 0; c < NUM_CH; c++)
          acc[c] <= acc[c] + pop[c];
    end
  end

  assign acc_out = acc;
`endif

endmodule

// File: tb/tb_sng_dsc_stream.sv
// Directed checks for sng_dsc_stream across three
// parameter sets; ACC checks with SNG_DSC_STREAM_ACC_EN.
module tb_sng_dsc_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // a: W=4 N=2 S=1
  logic       a_mode, a_iv, a_irdy, a_ov, a_ordy, a_last;
  logic [7:0] a_bin;
  logic [1:0] a_sn;
  // b: W=2 N=2 S=1
  logic       b_mode, b_iv, b_irdy, b_ov, b_ordy, b_last;
  logic [3:0] b_bin;
  logic [1:0] b_sn;
  // c: W=4 N=2 S=4
  logic       c_mode, c_iv, c_irdy, c_ov, c_ordy, c_last;
  logic [7:0] c_bin;
  logic [7:0] c_sn;
`ifdef SNG_DSC_STREAM_ACC_EN
  logic [17:0] a_acc, c_acc;
  logic [9:0]  b_acc;
  logic        a_accv, b_accv, c_accv;
`endif

  sng_dsc_stream #(.WIDTH(4), .NUM_CH(2), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst), .mode(a_mode),
    .in_valid(a_iv), .in_ready(a_irdy), .bin_in(a_bin),
    .out_valid(a_ov), .out_ready(a_ordy),
    .sn_out(a_sn), .out_last(a_last)
`ifdef SNG_DSC_STREAM_ACC_EN
    , .acc_out(a_acc), .acc_valid(a_accv)
`endif
  );

  sng_dsc_stream #(.WIDTH(2), .NUM_CH(2), .STRIDE(1)) u_b (
    .clk(clk), .rst(rst), .mode(b_mode),
    .in_valid(b_iv), .in_ready(b_irdy), .bin_in(b_bin),
    .out_valid(b_ov), .out_ready(b_ordy),
    .sn_out(b_sn), .out_last(b_last)
`ifdef SNG_DSC_STREAM_ACC_EN
    , .acc_out(b_acc), .acc_valid(b_accv)
`endif
  );

  sng_dsc_stream #(.WIDTH(4), .NUM_CH(2), .STRIDE(4)) u_c (
    .clk(clk), .rst(rst), .mode(c_mode),
    .in_valid(c_iv), .in_ready(c_irdy), .bin_in(c_bin),
    .out_valid(c_ov), .out_ready(c_ordy),
    .sn_out(c_sn), .out_last(c_last)
`ifdef SNG_DSC_STREAM_ACC_EN
    , .acc_out(c_acc), .acc_valid(c_accv)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b0;
    {a_mode, a_iv, a_ordy, a_bin} = '0;
    {b_mode, b_iv, b_ordy, b_bin} = '0;
    {c_mode, c_iv, c_ordy, c_bin} = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({a_ov, a_last, a_sn, a_irdy} !== 5'b00001)
      $display("FAIL reset_a got %b want 00001",
               {a_ov, a_last, a_sn, a_irdy});
    else pass_cnt++;
    chk_cnt++;
    if ({b_ov, b_last, b_sn, b_irdy} !== 5'b00001)
      $display("FAIL reset_b got %b want 00001",
               {b_ov, b_last, b_sn, b_irdy});
    else pass_cnt++;
    chk_cnt++;
    if ({c_ov, c_last, c_sn, c_irdy} !== 11'b1)
      $display("FAIL reset_c got %b want 00000000001",
               {c_ov, c_last, c_sn, c_irdy});
    else pass_cnt++;
`ifdef SNG_DSC_STREAM_ACC_EN
    chk_cnt++;
    if ({b_accv, b_acc} !== 11'b0)
      $display("FAIL reset_acc got %b want 0",
               {b_accv, b_acc});
    else pass_cnt++;
`endif
    rst = 1'b1;
  endtask

  task automatic test_shared();
    logic [3:0] exp_v;
    a_bin = 8'hC5; a_mode = 1'b0;
    a_iv = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk_cnt++;
    if (a_irdy !== 1'b0)
      $display("FAIL shared_busy got %b want 0", a_irdy);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, k == 15, k < 12, k < 5};
      chk_cnt++;
      if ({a_ov, a_last, a_sn} !== exp_v)
        $display("FAIL shared_beat%0d got %b want %b",
                 k, {a_ov, a_last, a_sn}, exp_v);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({a_ov, a_irdy} !== 2'b01)
      $display("FAIL shared_end got %b want 01",
               {a_ov, a_irdy});
    else pass_cnt++;
  endtask

  task automatic test_clkdiv();
    logic [3:0] exp_v;
    int o0, o1, oa;
    o0 = 0; o1 = 0; oa = 0;
    b_bin = 4'h9; b_mode = 1'b1;
    b_iv = 1'b1; b_ordy = 1'b1;
    @(negedge clk);
    // keep requesting with new operands while busy
    b_bin = 4'h0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, k == 15, k < 8, (k % 4) == 0};
      chk_cnt++;
      if ({b_ov, b_last, b_sn} !== exp_v)
        $display("FAIL clkdiv_beat%0d got %b want %b",
                 k, {b_ov, b_last, b_sn}, exp_v);
      else pass_cnt++;
      o0 += int'(b_sn[0]);
      o1 += int'(b_sn[1]);
      oa += int'(b_sn[0] & b_sn[1]);
      if (k == 15) b_iv = 1'b0;
      @(negedge clk);
    end
    chk_cnt++;
    if (o0 != 4 || o1 != 8 || oa != 2)
      $display("FAIL clkdiv_ones got %0d/%0d/%0d want 4/8/2",
               o0, o1, oa);
    else pass_cnt++;
    chk_cnt++;
    if ({b_ov, b_irdy} !== 2'b01)
      $display("FAIL clkdiv_end got %b want 01",
               {b_ov, b_irdy});
    else pass_cnt++;
`ifdef SNG_DSC_STREAM_ACC_EN
    chk_cnt++;
    if ({b_accv, b_acc} !== {1'b1, 5'd8, 5'd4})
      $display("FAIL acc_pulse got %b want %b",
               {b_accv, b_acc}, {1'b1, 5'd8, 5'd4});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({b_accv, b_acc} !== {1'b0, 5'd8, 5'd4})
      $display("FAIL acc_hold got %b want %b",
               {b_accv, b_acc}, {1'b0, 5'd8, 5'd4});
    else pass_cnt++;
`endif
  endtask

  task automatic test_stride4();
    logic [7:0] exp_sn [4];
    logic [9:0] exp_v;
    exp_sn = '{8'hF0, 8'hF0, 8'hF0, 8'h70};
    c_bin = 8'hF0; c_mode = 1'b0;
    c_iv = 1'b1; c_ordy = 1'b1;
    @(negedge clk);
    c_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, k == 3, exp_sn[k]};
      chk_cnt++;
      if ({c_ov, c_last, c_sn} !== exp_v)
        $display("FAIL stride4_beat%0d got %h want %h",
                 k, {c_ov, c_last, c_sn}, exp_v);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({c_ov, c_irdy} !== 2'b01)
      $display("FAIL stride4_end got %b want 01",
               {c_ov, c_irdy});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int beats, o0, o1, stalls;
    bit stalled, got_last;
    logic [2:0] held, exp_v;
    beats = 0; o0 = 0; o1 = 0; stalls = 0;
    stalled = 0; got_last = 0; held = '0;
    a_bin = 8'hC5; a_mode = 1'b0;
    a_iv = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_last; cyc++) begin
      if (stalled) begin
        chk_cnt++;
        if ({a_ov, a_last, a_sn} !== {1'b1, held})
          $display("FAIL bp_hold got %b want %b",
                   {a_ov, a_last, a_sn}, {1'b1, held});
        else pass_cnt++;
      end
      a_ordy = ($urandom_range(0, 9) >= 3);
      if (a_ov) begin
        exp_v = {beats == 15, beats < 12, beats < 5};
        chk_cnt++;
        if ({a_last, a_sn} !== exp_v)
          $display("FAIL bp_beat%0d got %b want %b",
                   beats, {a_last, a_sn}, exp_v);
        else pass_cnt++;
        if (a_ordy) begin
          beats++;
          o0 += int'(a_sn[0]);
          o1 += int'(a_sn[1]);
          if (a_last) got_last = 1;
          stalled = 0;
        end else begin
          stalls++;
          stalled = 1;
          held = {a_last, a_sn};
        end
      end
      @(negedge clk);
    end
    a_ordy = 1'b1;
    chk_cnt++;
    if (!got_last || beats != 16 || o0 != 5 || o1 != 12)
      $display("FAIL bp_totals got %0d/%0d/%0d want 16/5/12",
               beats, o0, o1);
    else pass_cnt++;
    chk_cnt++;
    if ({a_ov, a_irdy} !== 2'b01)
      $display("FAIL bp_end got %b want 01", {a_ov, a_irdy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    a_bin = 8'hC5; a_mode = 1'b0;
    a_iv = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    repeat (7) @(negedge clk);
    chk_cnt++;
    if ({a_ov, a_last, a_sn} !== 4'b1010)
      $display("FAIL rmid_beat7 got %b want 1010",
               {a_ov, a_last, a_sn});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_cnt++;
    if ({a_ov, a_last, a_sn, a_irdy} !== 5'b00001)
      $display("FAIL rmid_clear got %b want 00001",
               {a_ov, a_last, a_sn, a_irdy});
    else pass_cnt++;
    a_bin = 8'h93; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, k == 15, k < 9, k < 3};
      chk_cnt++;
      if ({a_ov, a_last, a_sn} !== exp_v)
        $display("FAIL rmid_beat%0d got %b want %b",
                 k, {a_ov, a_last, a_sn}, exp_v);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({a_ov, a_irdy} !== 2'b01)
      $display("FAIL rmid_end got %b want 01",
               {a_ov, a_irdy});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_shared();
    test_clkdiv();
    test_stride4();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
